// File: rtl/apb_timer_multi.sv
// apb_timer_multi
//   Multi-channel APB timer. It is a 4KB APB slave with N_TIMERS independent
//   channels. Each channel has a counter, a prescaler, a compare register and
//   a control register. Compare and overflow status bits are sticky, are
//   cleared by writing 1, and feed a per-channel level interrupt.
//
// Ports
//   HCLK      in   clock
//   HRESETn   in   synchronous active-low reset
//   PADDR     in   APB address (APB_ADDR_WIDTH)
//   PWDATA    in   APB write data (32)
//   PWRITE    in   APB write strobe
//   PSEL      in   APB select
//   PENABLE   in   APB enable
//   PRDATA    out  APB read data (32), zero outside a read access
//   PREADY    out  always 1 (zero wait states)
//   PSLVERR   out  error on an unmapped access
//   irq_o     out  per-channel level interrupt (N_TIMERS)
//
// Register map
//   PADDR[8]=0 : ch = PADDR[7:4], reg = PADDR[3:2]
//                0x0 COUNT, 0x4 PRESC, 0x8 CMP,
//                0xC CTRL {[4] CASCADE, [3] OVF_IE, [2] CMP_IE, [1] ONESHOT, [0] EN}
//   0x100      : STATUS, bit 2i = CMP_i, bit 2i+1 = OVF_i (write 1 to clear)
//
// Build option
//   TIMER_CASCADE_EN : when defined, CTRL[4] CASCADE exists for channels >= 1.
//                      A cascaded channel ticks on the compare event of the
//                      channel below it instead of on its own prescaler.

module apb_timer_multi #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_TIMERS       = 4,
    parameter int TIMER_WIDTH    = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [N_TIMERS-1:0]       irq_o
);

    localparam logic [1:0] REG_COUNT = 2'd0;
    localparam logic [1:0] REG_PRESC = 2'd1;
    localparam logic [1:0] REG_CMP   = 2'd2;

    // Per-channel state
    logic [N_TIMERS-1:0][TIMER_WIDTH-1:0] count_q, count_d;
    logic [N_TIMERS-1:0][TIMER_WIDTH-1:0] presc_q, presc_d;
    logic [N_TIMERS-1:0][TIMER_WIDTH-1:0] cmp_q,   cmp_d;
    logic [N_TIMERS-1:0][TIMER_WIDTH-1:0] pcnt_q,  pcnt_d;
    logic [N_TIMERS-1:0] en_q,      en_d;
    logic [N_TIMERS-1:0] oneshot_q, oneshot_d;
    logic [N_TIMERS-1:0] cmp_ie_q,  cmp_ie_d;
    logic [N_TIMERS-1:0] ovf_ie_q,  ovf_ie_d;
    logic [N_TIMERS-1:0] st_cmp_q,  st_cmp_d;
    logic [N_TIMERS-1:0] st_ovf_q,  st_ovf_d;
`ifdef TIMER_CASCADE_EN
    logic [N_TIMERS-1:0] casc_q,    casc_d;
`endif

    // Event signals
    logic [N_TIMERS-1:0] own_tick;
    logic [N_TIMERS-1:0] tick;
    logic [N_TIMERS-1:0] cmp_evt;
    logic [N_TIMERS-1:0] ovf_evt;

    // APB decode
    logic [31:0]         addr_ext;
    logic [3:0]          ch;
    logic [1:0]          rsel;
    logic                access;
    logic                in_chan;
    logic                in_status;
    logic                mapped;
    logic                wr_acc;
    logic                rd_acc;
    logic                status_wr;
    logic [N_TIMERS-1:0] chan_wr;
    logic [31:0]         rdata;
    logic                unused_bits;

    assign addr_ext  = 32'(PADDR);
    assign ch        = addr_ext[7:4];
    assign rsel      = addr_ext[3:2];
    assign access    = PSEL & PENABLE;
    // Only the 0x000-0x0FF channel window and the single STATUS word decode;
    // anything else in the 4KB window is an error.
    assign in_chan   = (addr_ext[31:8] == 24'd0) && (int'(ch) < N_TIMERS);
    assign in_status = (addr_ext[31:2] == 30'h40);
    assign mapped    = in_chan | in_status;
    assign wr_acc    = access & PWRITE & mapped;
    assign rd_acc    = access & ~PWRITE & mapped;
    assign status_wr = wr_acc & in_status;

    // Byte offset within a word is ignored; write data bits above the
    // implemented fields are dropped.
    assign unused_bits = ^{addr_ext[1:0], PWDATA};

    always_comb begin
        chan_wr = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            chan_wr[i] = wr_acc && in_chan && (ch == 4'(i));
        end
    end

    // Tick and event generation. Compare takes precedence over overflow so a
    // compare value of all-ones reports a compare, not an overflow.
    always_comb begin
`ifdef TIMER_CASCADE_EN
        logic prev_cmp;
        prev_cmp = 1'b0;
`endif
        own_tick = '0;
        tick     = '0;
        cmp_evt  = '0;
        ovf_evt  = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            own_tick[i] = en_q[i] && (pcnt_q[i] == presc_q[i]);
            tick[i]     = own_tick[i];
`ifdef TIMER_CASCADE_EN
            // Same-cycle ripple: a cascaded channel sees the lower channel's
            // compare event in the cycle it happens.
            if (casc_q[i]) begin
                tick[i] = en_q[i] && prev_cmp;
            end
`endif
            cmp_evt[i] = tick[i] && (cmp_q[i] != '0) && (count_q[i] == cmp_q[i]);
            ovf_evt[i] = tick[i] && !cmp_evt[i] && (count_q[i] == '1);
`ifdef TIMER_CASCADE_EN
            prev_cmp = cmp_evt[i];
`endif
        end
    end

    // Next-state: hardware updates first, APB writes last so they win.
    always_comb begin
        count_d   = count_q;
        presc_d   = presc_q;
        cmp_d     = cmp_q;
        pcnt_d    = pcnt_q;
        en_d      = en_q;
        oneshot_d = oneshot_q;
        cmp_ie_d  = cmp_ie_q;
        ovf_ie_d  = ovf_ie_q;
        st_cmp_d  = st_cmp_q;
        st_ovf_d  = st_ovf_q;
`ifdef TIMER_CASCADE_EN
        casc_d    = casc_q;
`endif
        for (int i = 0; i < N_TIMERS; i++) begin
            // Prescaler: restart on COUNT/PRESC write so the next tick is a
            // full period after the write.
            if (chan_wr[i] && ((rsel == REG_COUNT) || (rsel == REG_PRESC))) begin
                pcnt_d[i] = '0;
            end else if (own_tick[i]) begin
                pcnt_d[i] = '0;
            end else if (en_q[i]) begin
                pcnt_d[i] = pcnt_q[i] + TIMER_WIDTH'(1);
            end

            if (cmp_evt[i] || ovf_evt[i]) begin
                count_d[i] = '0;
            end else if (tick[i]) begin
                count_d[i] = count_q[i] + TIMER_WIDTH'(1);
            end

            if (cmp_evt[i] && oneshot_q[i]) begin
                en_d[i] = 1'b0;
            end

            if (chan_wr[i]) begin
                case (rsel)
                    REG_COUNT: count_d[i] = PWDATA[TIMER_WIDTH-1:0];
                    REG_PRESC: presc_d[i] = PWDATA[TIMER_WIDTH-1:0];
                    REG_CMP:   cmp_d[i]   = PWDATA[TIMER_WIDTH-1:0];
                    default: begin
                        en_d[i]      = PWDATA[0];
                        oneshot_d[i] = PWDATA[1];
                        cmp_ie_d[i]  = PWDATA[2];
                        ovf_ie_d[i]  = PWDATA[3];
`ifdef TIMER_CASCADE_EN
                        casc_d[i]    = (i > 0) ? PWDATA[4] : 1'b0;
`endif
                    end
                endcase
            end

            // Status: a same-cycle hardware set beats the W1C clear.
            if (status_wr && PWDATA[2*i]) begin
                st_cmp_d[i] = 1'b0;
            end
            if (status_wr && PWDATA[2*i+1]) begin
                st_ovf_d[i] = 1'b0;
            end
            if (cmp_evt[i]) begin
                st_cmp_d[i] = 1'b1;
            end
            if (ovf_evt[i]) begin
                st_ovf_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            count_q   <= '0;
            presc_q   <= '0;
            cmp_q     <= '0;
            pcnt_q    <= '0;
            en_q      <= '0;
            oneshot_q <= '0;
            cmp_ie_q  <= '0;
            ovf_ie_q  <= '0;
            st_cmp_q  <= '0;
            st_ovf_q  <= '0;
`ifdef TIMER_CASCADE_EN
            casc_q    <= '0;
`endif
        end else begin
            count_q   <= count_d;
            presc_q   <= presc_d;
            cmp_q     <= cmp_d;
            pcnt_q    <= pcnt_d;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            cmp_ie_q  <= cmp_ie_d;
            ovf_ie_q  <= ovf_ie_d;
            st_cmp_q  <= st_cmp_d;
            st_ovf_q  <= st_ovf_d;
`ifdef TIMER_CASCADE_EN
            casc_q    <= casc_d;
`endif
        end
    end

    // Read mux, combinational from current state
    always_comb begin
        rdata = '0;
        if (in_status) begin
            for (int i = 0; i < N_TIMERS; i++) begin
                rdata[2*i]   = st_cmp_q[i];
                rdata[2*i+1] = st_ovf_q[i];
            end
        end else if (in_chan) begin
            for (int i = 0; i < N_TIMERS; i++) begin
                if (ch == 4'(i)) begin
                    case (rsel)
                        REG_COUNT: rdata = 32'(count_q[i]);
                        REG_PRESC: rdata = 32'(presc_q[i]);
                        REG_CMP:   rdata = 32'(cmp_q[i]);
`ifdef TIMER_CASCADE_EN
                        default:   rdata = {27'd0, casc_q[i], ovf_ie_q[i], cmp_ie_q[i],
                                            oneshot_q[i], en_q[i]};
`else
                        default:   rdata = {28'd0, ovf_ie_q[i], cmp_ie_q[i],
                                            oneshot_q[i], en_q[i]};
`endif
                    endcase
                end
            end
        end
    end

    assign PRDATA  = rd_acc ? rdata : 32'd0;
    assign PREADY  = 1'b1;
    assign PSLVERR = access & ~mapped;
    assign irq_o   = (st_cmp_q & cmp_ie_q) | (st_ovf_q & ovf_ie_q);

endmodule
